dp_sequencer: RTL and testbench

//   Control sequencer for the 8-bit RA/RB/RZ adder datapath. Accepts one command per start/done

---
 rtl/dp_sequencer_if.sv | 27 ++
 rtl/dp_sequencer.sv | 127 ++++++++++++
 tb/tb_dp_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/dp_sequencer_if.sv
// rtl/dp_sequencer_if.sv - command handshake and datapath strobe bundle for dp_sequencer
interface dp_sequencer_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic [2:0]       opcode;
    logic [CNT_W-1:0] count;
    logic             RAin;
    logic             RBin;
    logic             RZin;
    logic             RAout;
    logic             RBout;
    logic             RZout;
    logic             busy;
    logic             done;
    logic             err;

    modport slave (
        input  start, opcode, count,
        output RAin, RBin, RZin, RAout, RBout, RZout, busy, done, err
    );

    modport master (
        output start, opcode, count,
        input  RAin, RBin, RZin, RAout, RBout, RZout, busy, done, err
    );
endinterface

// File: rtl/dp_sequencer.sv
// rtl/dp_sequencer.sv - command sequencer driving RA/RB/RZ load enables and bus selects
module dp_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic          clock,
    input  logic          clear,
    dp_sequencer_if.slave ctl
);
    typedef enum logic [1:0] {IDLE, STEP1, STEP2, DONE} state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LDA  = 3'd1;
    localparam logic [2:0] OP_MVAB = 3'd2;
    localparam logic [2:0] OP_ADDA = 3'd3;
    localparam logic [2:0] OP_ADDB = 3'd4;
    localparam logic [2:0] OP_MVZB = 3'd5;
    localparam logic [2:0] OP_ACCN = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    // strobe vector order: {RAin, RBin, RZin, RAout, RBout, RZout}
    localparam logic [5:0] S_NONE = 6'b000_000;
    localparam logic [5:0] S_LDA  = 6'b100_000;
    localparam logic [5:0] S_MVAB = 6'b010_100;
    localparam logic [5:0] S_ADDA = 6'b001_100;
    localparam logic [5:0] S_ADDB = 6'b001_010;
    localparam logic [5:0] S_MVZB = 6'b010_001;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       strb_q, strb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            strb_q  <= S_NONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            strb_q  <= strb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Outputs are computed for the next state and registered alongside it.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        strb_d  = S_NONE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctl.start) begin
                    op_d   = ctl.opcode;
                    cnt_d  = ctl.count;
                    busy_d = 1'b1;
                    if (ctl.opcode == OP_NOP || ctl.opcode == OP_RSVD ||
                        (ctl.opcode == OP_ACCN && ctl.count == '0)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = (ctl.opcode == OP_RSVD);
                    end else begin
                        state_d = STEP1;
                        case (ctl.opcode)
                            OP_LDA:  strb_d = S_LDA;
                            OP_MVAB: strb_d = S_MVAB;
                            OP_ADDA: strb_d = S_ADDA;
                            OP_ADDB: strb_d = S_ADDB;
                            OP_MVZB: strb_d = S_MVZB;
                            OP_ACCN: strb_d = S_ADDB;
                            default: strb_d = S_NONE;
                        endcase
                    end
                end
            end
            STEP1: begin
                busy_d = 1'b1;
                if (op_q == OP_ACCN) begin
                    state_d = STEP2;
                    strb_d  = S_MVZB;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            STEP2: begin
                busy_d = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                // cnt_q still holds the iteration just finished
                if (cnt_q > CNT_W'(1)) begin
                    state_d = STEP1;
                    strb_d  = S_ADDB;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign {ctl.RAin, ctl.RBin, ctl.RZin, ctl.RAout, ctl.RBout, ctl.RZout} = strb_q;
    assign ctl.busy = busy_q;
    assign ctl.done = done_q;
    assign ctl.err  = err_q;
endmodule

// File: tb/tb_dp_sequencer.sv
// tb/tb_dp_sequencer.sv - scoreboard bench for dp_sequencer with a behavioural RA/RB/RZ datapath
module tb_dp_sequencer;
    logic clock = 1'b0;
    logic clear = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   strobe_cnt = 0;
    logic [7:0] imm = '0;
    logic [7:0] ra = '0, rb = '0, rz = '0;
    logic [7:0] bus;

    typedef struct {
        int   n;
        int   lat;
        logic err;
        int   strobes;
    } exp_t;
    exp_t exp_q[$];

    dp_sequencer_if #(.CNT_W(4)) ctl ();

    dp_sequencer #(.CNT_W(4)) dut (
        .clock (clock),
        .clear (clear),
        .ctl   (ctl)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic logic [8:0] outs();
        return {ctl.RAin, ctl.RBin, ctl.RZin, ctl.RAout, ctl.RBout, ctl.RZout,
                ctl.busy, ctl.done, ctl.err};
    endfunction

    // Datapath model and completion monitor, both sampled mid-cycle.
    always @(negedge clock) begin
        exp_t e;
        bus = ctl.RAout ? ra : ctl.RBout ? rb : ctl.RZout ? rz : 8'd0;
        check("sel_onehot", 32'($countones({ctl.RAout, ctl.RBout, ctl.RZout}) <= 1), 32'd1);
        check("load_onehot", 32'($countones({ctl.RAin, ctl.RBin, ctl.RZin}) <= 1), 32'd1);
        if (ctl.RZin) rz = ra + bus;
        if (ctl.RBin) rb = bus;
        if (ctl.RAin) ra = imm;
        if (!clear) strobe_cnt = 0;
        else if (ctl.RAin | ctl.RBin | ctl.RZin | ctl.RAout | ctl.RBout | ctl.RZout)
            strobe_cnt++;
        if (ctl.err && !ctl.done) check("err_without_done", 32'd1, 32'd0);
        if (ctl.done) begin
            check("busy_at_done", 32'(ctl.busy), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", 32'(cyc + 1), 32'(e.n + e.lat));
                check("err", 32'(ctl.err), 32'(e.err));
                check("strobe_cycles", 32'(strobe_cnt), 32'(e.strobes));
            end
            strobe_cnt = 0;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [3:0] cnt, input int lat,
                         input int nstr, input bit push);
        exp_t e;
        @(negedge clock);
        ctl.start  = 1'b1;
        ctl.opcode = op;
        ctl.count  = cnt;
        @(posedge clock);
        #1;
        ctl.start = 1'b0;
        if (push) begin
            e.n = cyc; e.lat = lat; e.err = (op == 3'd7); e.strobes = nstr;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clock);
            #1;
            if (exp_q.size() == 0 && !ctl.busy) ok = 1'b1;
        end
        if (!ok) begin
            check("timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
    endtask

    task automatic run(input logic [2:0] op, input logic [7:0] value, input logic [3:0] cnt,
                       input int lat, input int nstr);
        imm = value;
        issue(op, cnt, lat, nstr, 1'b1);
        wait_done();
    endtask

    initial begin
        ctl.start  = 1'b1;
        ctl.opcode = 3'd6;
        ctl.count  = 4'd5;
        repeat (3) @(negedge clock);
        #1;
        check("reset_outs", 32'(outs()), 32'd0);
        @(negedge clock);
        ctl.start = 1'b0;
        clear     = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("idle_busy", 32'(ctl.busy), 32'd0);
        check("idle_outs", 32'(outs()), 32'd0);

        run(3'd1, 8'd7, 4'd0, 2, 1);
        run(3'd2, 8'd0, 4'd0, 2, 1);
        run(3'd1, 8'd3, 4'd0, 2, 1);
        run(3'd4, 8'd0, 4'd0, 2, 1);
        check("rb_mvab", 32'(rb), 32'd7);
        check("rz_addb", 32'(rz), 32'd10);
        run(3'd3, 8'd0, 4'd0, 2, 1);
        check("rz_adda", 32'(rz), 32'd6);
        run(3'd5, 8'd0, 4'd0, 2, 1);
        check("rb_mvzb", 32'(rb), 32'd6);

        run(3'd1, 8'd0, 4'd0, 2, 1);
        run(3'd2, 8'd0, 4'd0, 2, 1);
        run(3'd1, 8'd5, 4'd0, 2, 1);
        run(3'd6, 8'd0, 4'd3, 7, 6);
        check("rb_accn3", 32'(rb), 32'd15);

        run(3'd6, 8'd0, 4'd0, 1, 0);
        run(3'd7, 8'd0, 4'd9, 1, 0);
        run(3'd0, 8'd0, 4'd0, 1, 0);

        imm = 8'd99;
        issue(3'd6, 4'd2, 5, 4, 1'b1);
        @(negedge clock);
        ctl.start  = 1'b1;
        ctl.opcode = 3'd1;
        @(negedge clock);
        ctl.start = 1'b0;
        wait_done();
        check("ra_after_ignored", 32'(ra), 32'd5);
        check("rb_accn2", 32'(rb), 32'd25);

        run(3'd1, 8'd1, 4'd0, 2, 1);
        issue(3'd6, 4'd4, 9, 8, 1'b0);
        repeat (3) @(negedge clock);
        #2;
        check("pre_clear_busy", 32'(ctl.busy), 32'd1);
        clear = 1'b0;
        #1;
        check("clear_outs", 32'(outs()), 32'd0);
        repeat (3) @(negedge clock);
        check("clear_hold_outs", 32'(outs()), 32'd0);
        clear = 1'b1;
        run(3'd0, 8'd0, 4'd0, 1, 0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
